mem_port_sched: RTL and testbench

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

---
 rtl/mem_port_sched.sv | 139 +++++++++++++
 tb/tb_mem_port_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - two-requester memory port scheduler with alternating priority and ack timeout
module mem_port_sched #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic              req_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic              we_2,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              grant_1,
    output logic              grant_2,
    output logic              done_1,
    output logic              done_2,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Last BUSY cycle index before giving up; the counter reads 0 in the first BUSY cycle.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              sel_2, sel_2_nxt;
    logic [7:0]        wait_cnt, wait_cnt_nxt;
    logic              grant_1_nxt, grant_2_nxt, done_1_nxt, done_2_nxt;
    logic              err_nxt, mem_req_nxt, mem_we_nxt;
    logic [DATA_W-1:0] rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              pick_2;

    // Port 2 wins when it is alone, or when both ask and port 1 was served last.
    assign pick_2 = req_2 && (!req_1 || !last_grant);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        sel_2_nxt      = sel_2;
        wait_cnt_nxt   = wait_cnt;
        grant_1_nxt    = 1'b0;
        grant_2_nxt    = 1'b0;
        done_1_nxt     = 1'b0;
        done_2_nxt     = 1'b0;
        err_nxt        = err;
        rdata_nxt      = rdata;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        mem_we_nxt     = mem_we;
        mem_wdata_nxt  = mem_wdata;
        case (state)
            IDLE: begin
                if (req_1 || req_2) begin
                    sel_2_nxt      = pick_2;
                    last_grant_nxt = pick_2;
                    grant_1_nxt    = !pick_2;
                    grant_2_nxt    = pick_2;
                    mem_req_nxt    = 1'b1;
                    mem_addr_nxt   = pick_2 ? addr_2 : addr_1;
                    mem_we_nxt     = pick_2 && we_2;
                    mem_wdata_nxt  = pick_2 ? wdata_2 : '0;
                    wait_cnt_nxt   = 8'd0;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    rdata_nxt   = mem_we ? '0 : mem_rdata;
                    err_nxt     = 1'b0;
                    done_1_nxt  = !sel_2;
                    done_2_nxt  = sel_2;
                    state_nxt   = RESP;
                end else if (wait_cnt == TIMEOUT_M1) begin
                    mem_req_nxt = 1'b0;
                    rdata_nxt   = '0;
                    err_nxt     = 1'b1;
                    done_1_nxt  = !sel_2;
                    done_2_nxt  = sel_2;
                    state_nxt   = RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            sel_2      <= 1'b0;
            wait_cnt   <= 8'd0;
            grant_1    <= 1'b0;
            grant_2    <= 1'b0;
            done_1     <= 1'b0;
            done_2     <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            sel_2      <= sel_2_nxt;
            wait_cnt   <= wait_cnt_nxt;
            grant_1    <= grant_1_nxt;
            grant_2    <= grant_2_nxt;
            done_1     <= done_1_nxt;
            done_2     <= done_2_nxt;
            err        <= err_nxt;
            rdata      <= rdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_we     <= mem_we_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - directed and randomized transactions against a transaction-level scheduler model
module tb_mem_port_sched;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_1, req_2, we_2, mem_ack;
    logic [AW-1:0] addr_1, addr_2;
    logic [DW-1:0] wdata_2, mem_rdata;
    logic          grant_1, grant_2, done_1, done_2, err, mem_req, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks   = 0;
    int failures = 0;
    bit model_last = 1'b0;  // 1 when port 2 was the most recent winner

    always #5 clk = ~clk;

    mem_port_sched #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_1(req_1), .addr_1(addr_1),
        .req_2(req_2), .addr_2(addr_2), .we_2(we_2), .wdata_2(wdata_2),
        .grant_1(grant_1), .grant_2(grant_2), .done_1(done_1), .done_2(done_2),
        .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int winner(input bit r1, input bit r2);
        if (r1 && r2) return model_last ? 1 : 2;
        return r1 ? 1 : 2;
    endfunction

    // ack_k: BUSY cycle (1 = grant cycle) in which mem_ack is raised; beyond TO means never.
    task automatic run_txn(input bit r1, input bit r2, input bit we, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_k, input bit drop);
        int port;
        int cyc;
        bit e_err;
        bit seen;
        logic [31:0] e_addr;
        logic [31:0] e_rdata;
        port       = winner(r1, r2);
        model_last = (port == 2);
        e_err      = (ack_k > TO);
        e_addr     = (port == 1) ? a1 : a2;
        e_rdata    = (e_err || (port == 2 && we)) ? 32'h0 : rd;
        seen       = 1'b0;
        req_1 = r1; addr_1 = a1; req_2 = r2; addr_2 = a2;
        we_2 = we; wdata_2 = wd; mem_rdata = rd;
        step();
        check("grant_1", 32'(grant_1), 32'(port == 1));
        check("grant_2", 32'(grant_2), 32'(port == 2));
        check("mem_we", 32'(mem_we), 32'(port == 2 && we));
        if (port == 2) check("mem_wdata", mem_wdata, wd);
        for (cyc = 1; cyc <= 40; cyc++) begin
            check("mem_req_busy", 32'(mem_req), 32'd1);
            check("mem_addr_hold", mem_addr, e_addr);
            mem_ack = (cyc == ack_k);
            if (drop && cyc == 2) begin
                req_1 = 1'b0;
                req_2 = 1'b0;
            end
            step();
            mem_ack = 1'b0;
            check("grant_one_shot", 32'(grant_1 | grant_2), 32'd0);
            if (done_1 || done_2) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_cycle", 32'(cyc), 32'(e_err ? TO : ack_k));
        check("done_1", 32'(done_1), 32'(port == 1));
        check("done_2", 32'(done_2), 32'(port == 2));
        check("mem_req_drop", 32'(mem_req), 32'd0);
        check("err", 32'(err), 32'(e_err));
        check("rdata", rdata, e_rdata);
        req_1 = 1'b0;
        req_2 = 1'b0;
        step();
        check("done_pulse_end", 32'(done_1 | done_2), 32'd0);
        check("rdata_hold", rdata, e_rdata);
        check("err_hold", 32'(err), 32'(e_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({grant_1, grant_2, done_1, done_2, err, mem_req, mem_we}), 32'd0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        int port;
        int n;
        int sel;
        reset = 1'b0;
        req_1 = 1'b1; req_2 = 1'b1; we_2 = 1'b0; mem_ack = 1'b0;
        addr_1 = 32'h1000; addr_2 = 32'h2000; wdata_2 = 32'h0; mem_rdata = 32'h5555AAAA;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Both requesters held from reset, memory acks one cycle after mem_req.
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!(grant_1 || grant_2) && n < 6) begin
                step();
                n++;
            end
            check("alt_grant_seen", 32'(grant_1 | grant_2), 32'd1);
            check("alt_not_both", 32'(grant_1 & grant_2), 32'd0);
            port       = winner(1'b1, 1'b1);
            model_last = (port == 2);
            check("alt_order", 32'(grant_2 ? 2 : 1), 32'(port));
            step();
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            check("alt_done", 32'(done_2 ? 2 : (done_1 ? 1 : 0)), 32'(port));
            check("alt_rdata", rdata, 32'h5555AAAA);
            step();
        end
        req_1 = 1'b0;
        req_2 = 1'b0;
        step();
        step();

        run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        check("fetch_addr_latched", mem_addr, 32'h100);
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h12345678, 32'hCAFEF00D, 2, 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 32'h11112222, 99, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h33334444, TO, 1'b0);
        run_txn(1'b1, 1'b1, 1'b0, 32'h400, 32'h500, 32'h0, 32'h55556666, 5, 1'b1);

        // Spurious ack while idle must not start anything.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("spurious_quiet", 32'({grant_1, grant_2, done_1, done_2, mem_req}), 32'd0);
        step();
        check("spurious_quiet2", 32'({grant_1, grant_2, done_1, done_2, mem_req}), 32'd0);
        run_txn(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 32'h77778888, 2, 1'b0);

        // Reset in the middle of a transaction.
        req_1 = 1'b1; addr_1 = 32'h700;
        step();
        check("pre_reset_grant", 32'(grant_1), 32'd1);
        step();
        check("pre_reset_busy", 32'(mem_req), 32'd1);
        reset = 1'b0;
        req_1 = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_last = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_quiet", 32'({grant_1, grant_2, done_1, done_2, mem_req}), 32'd0);
        end
        run_txn(1'b1, 1'b1, 1'b0, 32'h800, 32'h900, 32'h0, 32'h9999AAAA, 2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            sel = int'($urandom_range(1, 3));
            run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom, int'($urandom_range(2, TO + 2)), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
